alu_decode_issue: RTL and testbench
===================================

ALU_DECODE_ISSUE -- requirements
Module: alu_decode_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 INSTR_VALID  input  1  upstream instruction word valid.
REQ-005 INSTR  input  32  RV32I instruction word.
REQ-006 INSTR_READY  output  1  block can accept INSTR this cycle.
REQ-007 FLUSH  input  1  synchronous discard of all buffered entries.
REQ-008 OUT_VALID  output  1  decoded ALU command valid.
REQ-009 OUT_READY  input  1  ALU stage accepts the command.
REQ-010 FUNC3  output  3  ALU operation select, INSTR[14:12] or 000.
REQ-011 SUB  output  1  subtract / arithmetic-shift select.
REQ-012 ALU_EN  output  1  ALU result enable.
REQ-013 USE_IMM  output  1  second operand is IMM, not register RS2.
REQ-014 IMM  output  32  decoded immediate.
REQ-015 RS1_ADDR, RS2_ADDR, RD_ADDR  output  5 each  register indices.
REQ-016 ILLEGAL  output  1  entry is not a supported ALU instruction.
REQ-017 ILLEGAL_CNT  output  16  count of illegal entries issued.

Function
REQ-018 Transfer in occurs on INSTR_VALID & INSTR_READY; transfer out on OUT_VALID & OUT_READY.
REQ-019 Decode SHALL be combinational on INSTR and captured at transfer-in; latency 1 cycle (accept at edge N -> OUT_VALID high after edge N); throughput 1 per cycle.
REQ-020 OP (opcode 0110011): FUNC3=INSTR[14:12], SUB=INSTR[30], USE_IMM=0, IMM=0; legal only if funct7=0000000, or funct7=0100000 with funct3 000 or 101.
REQ-021 OP-IMM (0010011): FUNC3=INSTR[14:12], USE_IMM=1, RS2_ADDR=0; funct3 001: legal only if INSTR[31:25]=0, IMM={27'b0,INSTR[24:20]}, SUB=0; funct3 101: legal only if INSTR[31:25] is 0000000 or 0100000, IMM={27'b0,INSTR[24:20]}, SUB=INSTR[30]; other funct3: IMM=sign-extended INSTR[31:20], SUB=0.
REQ-022 LUI (0110111): FUNC3=000, SUB=0, USE_IMM=1, RS1_ADDR=0, RS2_ADDR=0, IMM={INSTR[31:12],12'b0}.
REQ-023 RS1_ADDR=INSTR[19:15], RS2_ADDR=INSTR[24:20], RD_ADDR=INSTR[11:7] unless overridden above.
REQ-024 Any other opcode or illegal funct7: ILLEGAL=1, ALU_EN=0, SUB=0, FUNC3=000, IMM=0, RD_ADDR=0; legal entries: ILLEGAL=0, ALU_EN=1.
REQ-025 Buffering SHALL be a 2-entry skid: output register (OREG) plus skid register (SREG); INSTR_READY SHALL be registered and equal ~SREG-valid.
REQ-026 Accept while OREG empty or draining -> entry to OREG; accept while OREG held (OUT_VALID & ~OUT_READY) -> entry to SREG, INSTR_READY low from next cycle.
REQ-027 When OREG drains and SREG valid, SREG moves to OREG and SREG clears the same edge; strict in-order, no loss or duplication.
REQ-028 All OREG outputs SHALL be stable while OUT_VALID & ~OUT_READY.
REQ-029 FLUSH SHALL clear both entries at the edge, override a simultaneous transfer-in (discarded), and leave ILLEGAL_CNT unchanged.
REQ-030 ILLEGAL_CNT SHALL increment on transfer-out of an entry with ILLEGAL=1, saturating at 0xFFFF.

Reset
REQ-031 RST_N low SHALL immediately force OUT_VALID=0, both entries invalid, INSTR_READY=1, all payload outputs 0, ILLEGAL_CNT=0, including mid-stall.
REQ-032 First transfer-in SHALL be possible on the first rising edge after RST_N deasserts.

Verification
REQ-033 INSTR=0x002081B3 (ADD x3,x1,x2), OUT_READY=1 -> next cycle OUT_VALID=1, FUNC3=000, SUB=0, ALU_EN=1, USE_IMM=0, RS1=1, RS2=2, RD=3.
REQ-034 INSTR=0x40735293 (SRAI x5,x6,7) -> FUNC3=101, SUB=1, USE_IMM=1, IMM=0x00000007; INSTR=0xFFF00093 (ADDI x1,x0,-1) -> IMM=0xFFFFFFFF, SUB=0.
REQ-035 INSTR=0x123453B7 (LUI x7) -> FUNC3=000, RS1=0, RD=7, IMM=0x12345000.
REQ-036 INSTR=0x400020B3 (funct7 0100000, funct3 010) -> ILLEGAL=1, ALU_EN=0; after transfer-out ILLEGAL_CNT=1; 65536 illegal issues -> ILLEGAL_CNT=0xFFFF.
REQ-037 OUT_READY=0, offer A,B,C back-to-back -> A,B accepted, INSTR_READY=0, C held; OUT_READY=1 -> A,B,C emitted in order on consecutive cycles, outputs stable during stall.
REQ-038 Both entries full, FLUSH=1 with INSTR_VALID=1 -> next cycle OUT_VALID=0, INSTR_READY=1, offered word dropped; RST_N pulsed low mid-stall -> outputs zero immediately.

Source files
------------

// File: rtl/alu_decode_issue.sv
// ---------------------------------------------------------------------------
// alu_decode_issue
//
// Decodes RV32I ALU instructions (OP, OP-IMM, LUI) into a flat ALU command
// and issues it through a two-entry skid buffer: an output register (oreg)
// that drives the command ports and a skid register (sreg) that catches one
// extra word when the ALU stage stalls. instr_ready is registered, so the
// upstream combinational path never depends on out_ready.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instr_valid  upstream instruction word valid
//   instr        RV32I instruction word
//   instr_ready  block can accept instr this cycle (registered)
//   flush        synchronous discard of both buffered entries
//   out_valid    decoded ALU command valid
//   out_ready    ALU stage accepts the command
//   func3        ALU operation select
//   sub          subtract / arithmetic-shift select
//   alu_en       ALU result enable (low for illegal entries)
//   use_imm      second operand is imm rather than rs2
//   imm          decoded immediate
//   rs1_addr, rs2_addr, rd_addr  register indices
//   illegal      entry is not a supported ALU instruction
//   illegal_cnt  saturating count of illegal entries issued
// ---------------------------------------------------------------------------
module alu_decode_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  func3,
  output logic        sub,
  output logic        alu_en,
  output logic        use_imm,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic        illegal,
  output logic [15:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  // One buffered ALU command; the same layout is used for both entries.
  typedef struct packed {
    logic [2:0]  func3;
    logic        sub;
    logic        alu_en;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        illegal;
  } cmd_t;

  // -------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // -------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  cmd_t       dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    dec          = '0;
    legal        = 1'b0;
    dec.rs1_addr = instr[19:15];
    dec.rs2_addr = instr[24:20];
    dec.rd_addr  = instr[11:7];

    case (opcode)
      OPC_OP: begin
        dec.func3 = funct3;
        dec.sub   = instr[30];
        // The alternate funct7 only exists for SUB and SRA.
        legal = (funct7 == F7_ZERO) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end

      OPC_OP_IMM: begin
        dec.func3    = funct3;
        dec.use_imm  = 1'b1;
        dec.rs2_addr = 5'd0;
        case (funct3)
          F3_SLL: begin
            // Shift amount is an unsigned 5-bit field; upper bits must be zero.
            dec.imm = {27'd0, instr[24:20]};
            legal   = (funct7 == F7_ZERO);
          end
          F3_SR: begin
            // instr[30] distinguishes SRAI from SRLI.
            dec.imm = {27'd0, instr[24:20]};
            dec.sub = instr[30];
            legal   = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          end
          default: begin
            dec.imm = {{20{instr[31]}}, instr[31:20]};
            legal   = 1'b1;
          end
        endcase
      end

      OPC_LUI: begin
        // Executed as 0 + imm, so rs1 is forced to x0.
        dec.func3    = F3_ADD;
        dec.use_imm  = 1'b1;
        dec.rs1_addr = 5'd0;
        dec.rs2_addr = 5'd0;
        dec.imm      = {instr[31:12], 12'd0};
        legal        = 1'b1;
      end

      default: begin
        legal = 1'b0;
      end
    endcase

    // An illegal entry must not write back anything meaningful.
    if (legal) begin
      dec.alu_en  = 1'b1;
      dec.illegal = 1'b0;
    end else begin
      dec.alu_en  = 1'b0;
      dec.illegal = 1'b1;
      dec.func3   = 3'd0;
      dec.sub     = 1'b0;
      dec.imm     = 32'd0;
      dec.rd_addr = 5'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Two-entry skid buffer
  // -------------------------------------------------------------------------
  cmd_t        oreg_reg,  oreg_next;
  cmd_t        sreg_reg,  sreg_next;
  logic        oreg_valid_reg, oreg_valid_next;
  logic        sreg_valid_reg, sreg_valid_next;
  logic        ready_reg, ready_next;
  logic [15:0] cnt_reg,   cnt_next;

  logic take_in;    // transfer-in this cycle
  logic drain;      // transfer-out this cycle
  logic oreg_free;  // oreg may be (re)loaded at the next edge

  assign take_in   = instr_valid & ready_reg;
  assign drain     = oreg_valid_reg & out_ready;
  assign oreg_free = ~oreg_valid_reg | out_ready;

  always_comb begin
    oreg_next       = oreg_reg;
    sreg_next       = sreg_reg;
    oreg_valid_next = oreg_valid_reg;
    sreg_valid_next = sreg_valid_reg;
    cnt_next        = cnt_reg;

    if (flush) begin
      // Payload is left as-is; it is meaningless once the valids drop.
      oreg_valid_next = 1'b0;
      sreg_valid_next = 1'b0;
    end else begin
      if (oreg_free) begin
        if (sreg_valid_reg) begin
          // Older skid entry goes first. ready_reg is low while sreg is
          // occupied, so no new word can arrive in the same cycle.
          oreg_next       = sreg_reg;
          oreg_valid_next = 1'b1;
          sreg_valid_next = 1'b0;
        end else if (take_in) begin
          oreg_next       = dec;
          oreg_valid_next = 1'b1;
        end else begin
          oreg_valid_next = 1'b0;
        end
      end else if (take_in) begin
        // oreg is stalled: park the new word; oreg stays untouched.
        sreg_next       = dec;
        sreg_valid_next = 1'b1;
      end

      if (drain && oreg_reg.illegal && (cnt_reg != 16'hFFFF)) begin
        cnt_next = cnt_reg + 16'd1;
      end
    end
  end

  // Ready is computed from the next skid state so it is already low in the
  // cycle after a word lands in sreg.
  assign ready_next = ~sreg_valid_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_reg       <= '0;
      sreg_reg       <= '0;
      oreg_valid_reg <= 1'b0;
      sreg_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
      cnt_reg        <= 16'd0;
    end else begin
      oreg_reg       <= oreg_next;
      sreg_reg       <= sreg_next;
      oreg_valid_reg <= oreg_valid_next;
      sreg_valid_reg <= sreg_valid_next;
      ready_reg      <= ready_next;
      cnt_reg        <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs straight from registers
  // -------------------------------------------------------------------------
  assign instr_ready = ready_reg;
  assign out_valid   = oreg_valid_reg;
  assign func3       = oreg_reg.func3;
  assign sub         = oreg_reg.sub;
  assign alu_en      = oreg_reg.alu_en;
  assign use_imm     = oreg_reg.use_imm;
  assign imm         = oreg_reg.imm;
  assign rs1_addr    = oreg_reg.rs1_addr;
  assign rs2_addr    = oreg_reg.rs2_addr;
  assign rd_addr     = oreg_reg.rd_addr;
  assign illegal     = oreg_reg.illegal;
  assign illegal_cnt = cnt_reg;

endmodule

// File: tb/tb_alu_decode_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_issue
//
// Self-checking bench: a table of known instruction encodings with their
// expected commands, hand-written stall / flush / reset sequences, and a
// randomized run compared every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_alu_decode_issue;

  typedef struct packed {
    logic [2:0]  func3;
    logic        sub;
    logic        alu_en;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
  } cmd_t;

  typedef struct {
    logic [31:0] instr;
    cmd_t        exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  func3;
  logic        sub;
  logic        alu_en;
  logic        use_imm;
  logic [31:0] imm;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        illegal;
  logic [15:0] illegal_cnt;

  cmd_t dut_cmd;
  assign dut_cmd = {func3, sub, alu_en, use_imm, imm, rs1_addr, rs2_addr, rd_addr, illegal};

  alu_decode_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .func3       (func3),
    .sub         (sub),
    .alu_en      (alu_en),
    .use_imm     (use_imm),
    .imm         (imm),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: FIFO of accepted words (at most two) and counter.
  logic [31:0] mq[$];
  int          mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected command derived from the ISA rules for each supported opcode.
  function automatic cmd_t ref_decode(input logic [31:0] w);
    cmd_t       c;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit         ok;
    op    = w[6:0];
    f3    = w[14:12];
    f7    = w[31:25];
    c     = '0;
    ok    = 1'b0;
    c.rs1 = w[19:15];
    c.rs2 = w[24:20];
    c.rd  = w[11:7];
    if (op == 7'h33) begin
      c.func3 = f3;
      c.sub   = w[30];
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (op == 7'h13) begin
      c.func3   = f3;
      c.use_imm = 1'b1;
      c.rs2     = 5'd0;
      if (f3 == 3'd1) begin
        c.imm = {27'd0, w[24:20]};
        ok    = (f7 == 7'h00);
      end else if (f3 == 3'd5) begin
        c.imm = {27'd0, w[24:20]};
        c.sub = w[30];
        ok    = (f7 == 7'h00) || (f7 == 7'h20);
      end else begin
        c.imm = {{20{w[31]}}, w[31:20]};
        ok    = 1'b1;
      end
    end else if (op == 7'h37) begin
      c.use_imm = 1'b1;
      c.rs1     = 5'd0;
      c.rs2     = 5'd0;
      c.imm     = {w[31:12], 12'd0};
      ok        = 1'b1;
    end
    if (ok) begin
      c.alu_en = 1'b1;
    end else begin
      c.illegal = 1'b1;
      c.func3   = 3'd0;
      c.sub     = 1'b0;
      c.imm     = 32'd0;
      c.rd      = 5'd0;
    end
    return c;
  endfunction

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_update(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit acc;
    bit drn;
    cmd_t head;
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && ordy;
    if (fl) begin
      mq.delete();
    end else begin
      if (drn) begin
        head = ref_decode(mq[0]);
        if (head.illegal && mcnt < 65535) mcnt++;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(w);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("instr_ready", 64'(instr_ready), 64'(mq.size() < 2));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
    if (mq.size() > 0) chk("payload", 64'(dut_cmd), 64'(ref_decode(mq[0])));
  endtask

  // Present inputs, clock once, then compare on the falling edge.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    instr_valid = v;
    instr       = w;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    model_update(v, w, ordy, fl);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    logic [31:0] w;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = r[31:25];
    endcase
    case ($urandom_range(0, 4))
      0:       w = {f7, r[24:7], 7'h33};
      1:       w = {f7, r[24:7], 7'h13};
      2:       w = {r[31:7], 7'h13};
      3:       w = {r[31:7], 7'h37};
      default: w = r;
    endcase
    return w;
  endfunction

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // func3, sub, alu_en, use_imm, imm, rs1, rs2, rd, illegal
    vecs[0] = '{32'h002081B3, '{3'd0, 1'b0, 1'b1, 1'b0, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b0}}; // ADD x3,x1,x2
    vecs[1] = '{32'h40735293, '{3'd5, 1'b1, 1'b1, 1'b1, 32'h00000007, 5'd6, 5'd0, 5'd5, 1'b0}}; // SRAI x5,x6,7
    vecs[2] = '{32'hFFF00093, '{3'd0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b0}}; // ADDI x1,x0,-1
    vecs[3] = '{32'h123453B7, '{3'd0, 1'b0, 1'b1, 1'b1, 32'h12345000, 5'd0, 5'd0, 5'd7, 1'b0}}; // LUI x7
    vecs[4] = '{32'h400020B3, '{3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1}}; // bad funct7
    vecs[5] = '{32'h40208033, '{3'd0, 1'b1, 1'b1, 1'b0, 32'h00000000, 5'd1, 5'd2, 5'd0, 1'b0}}; // SUB x0,x1,x2
    vecs[6] = '{32'h8000A113, '{3'd2, 1'b0, 1'b1, 1'b1, 32'hFFFFF800, 5'd1, 5'd0, 5'd2, 1'b0}}; // SLTI x2,x1,-2048
    vecs[7] = '{32'h00000073, '{3'd0, 1'b0, 1'b0, 1'b0, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1}}; // ECALL

    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'd0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_instr_ready", 64'(instr_ready), 64'd1);
    chk("reset_payload", 64'(dut_cmd), 64'd0);
    chk("reset_cnt", 64'(illegal_cnt), 64'd0);
    rst_n = 1'b1;

    // Table: back-to-back issue at full throughput, first word on the first
    // edge after reset release.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].instr, 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_cmd", i), 64'(dut_cmd), 64'(vecs[i].exp));
      $display("vec %0d instr=%h cmd=%h", i, vecs[i].instr, dut_cmd);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("table_cnt", 64'(illegal_cnt), 64'd2);

    // Stall: A and B buffered, C held off until the ALU stage resumes.
    step(1'b1, vecs[0].instr, 1'b0, 1'b0);
    chk("stall_a_ready", 64'(instr_ready), 64'd1);
    step(1'b1, vecs[1].instr, 1'b0, 1'b0);
    chk("stall_b_ready", 64'(instr_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vecs[3].instr, 1'b0, 1'b0);
      chk("stall_hold_ready", 64'(instr_ready), 64'd0);
      chk("stall_hold_cmd", 64'(dut_cmd), 64'(vecs[0].exp));
    end
    step(1'b1, vecs[3].instr, 1'b1, 1'b0);
    chk("release_b", 64'(dut_cmd), 64'(vecs[1].exp));
    step(1'b1, vecs[3].instr, 1'b1, 1'b0);
    chk("release_c", 64'(dut_cmd), 64'(vecs[3].exp));
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("release_empty", 64'(out_valid), 64'd0);
    $display("stall sequence done");

    // Flush with both entries full and a word offered at the same edge.
    step(1'b1, vecs[4].instr, 1'b0, 1'b0);
    step(1'b1, vecs[1].instr, 1'b0, 1'b0);
    step(1'b1, vecs[3].instr, 1'b0, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(instr_ready), 64'd1);
    chk("flush_cnt", 64'(illegal_cnt), 64'd2);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("flush_dropped", 64'(out_valid), 64'd0);
    $display("flush sequence done");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 3) != 0), rand_instr(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end
    $display("random run done cnt=%0d", illegal_cnt);

    // Reset asserted mid-stall with both entries occupied.
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, vecs[4].instr, 1'b0, 1'b0);
    step(1'b1, vecs[1].instr, 1'b0, 1'b0);
    chk("prerst_full", 64'(instr_ready), 64'd0);
    instr_valid = 1'b0;
    @(posedge clk);
    model_update(1'b0, 32'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_ready", 64'(instr_ready), 64'd1);
    chk("midrst_payload", 64'(dut_cmd), 64'd0);
    chk("midrst_cnt", 64'(illegal_cnt), 64'd0);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter increments on transfer-out of an illegal entry.
    step(1'b1, vecs[0].instr, 1'b1, 1'b0);
    chk("post_rst_accept", 64'(dut_cmd), 64'(vecs[0].exp));
    step(1'b1, vecs[4].instr, 1'b1, 1'b0);
    chk("ill_cnt_before", 64'(illegal_cnt), 64'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("ill_cnt_one", 64'(illegal_cnt), 64'd1);
    $display("illegal count=%0d", illegal_cnt);

    // Saturation after 65536 more illegal issues.
    for (int i = 0; i < 65536; i++) begin
      step(1'b1, vecs[4].instr, 1'b1, 1'b0);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("ill_cnt_sat", 64'(illegal_cnt), 64'hFFFF);
    step(1'b1, vecs[7].instr, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("ill_cnt_hold", 64'(illegal_cnt), 64'hFFFF);
    $display("saturation count=%h", illegal_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
